// File: rtl/wb_unified_mem_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter for the unified memory.
// Registered grant held for the whole bus cycle, with a bus-cycle watchdog that errors out hung transfers.
module wb_unified_mem_arbiter #(
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_we_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic [31:0] mwb_adr_o,
    output logic [31:0] mwb_dat_o,
    output logic        mwb_we_o,
    output logic [3:0]  mwb_sel_o,
    output logic        mwb_cyc_o,
    output logic        mwb_stb_o,
    input  logic [31:0] mwb_dat_i,
    input  logic        mwb_ack_i,
    input  logic        mwb_err_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               FIXED_D = (ARB_MODE != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             last_d_q, last_d_d;   // last owner: 0 = instruction, 1 = data
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic req_i, req_d, owned, resp, owner_cyc, wd_fire, pick_d;

    assign req_i     = iwb_cyc_i & iwb_stb_i;
    assign req_d     = dwb_cyc_i & dwb_stb_i;
    assign owned     = (state_q == OWN_I) || (state_q == OWN_D);
    assign resp      = mwb_ack_i | mwb_err_i;
    assign owner_cyc = (state_q == OWN_I) ? iwb_cyc_i : dwb_cyc_i;
    // A slave response on the final cycle wins over the forced error.
    assign wd_fire   = WD_EN && owned && !resp && (cnt_q == WD_LAST);
    assign pick_d    = req_d && (!req_i || FIXED_D || !last_d_q);

    // State, last-owner and watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, release owned cycle on response, abort or timeout
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    state_d  = pick_d ? OWN_D : OWN_I;
                    last_d_d = pick_d;
                    cnt_d    = '0;
                end
            end
            OWN_I, OWN_D: begin
                if (resp || !owner_cyc || wd_fire) begin
                    state_d = IDLE;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux and response steering, combinational from the registered owner
    always_comb begin
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_we_o  = 1'b0;
        mwb_sel_o = '0;
        mwb_cyc_o = 1'b0;
        mwb_stb_o = 1'b0;
        iwb_dat_o = '0;
        iwb_ack_o = 1'b0;
        iwb_err_o = 1'b0;
        dwb_dat_o = '0;
        dwb_ack_o = 1'b0;
        dwb_err_o = 1'b0;
        case (state_q)
            OWN_I: begin
                mwb_adr_o = iwb_adr_i;
                mwb_sel_o = 4'hF;
                mwb_cyc_o = iwb_cyc_i;
                mwb_stb_o = iwb_stb_i;
                iwb_dat_o = mwb_dat_i;
                iwb_ack_o = mwb_ack_i;
                iwb_err_o = mwb_err_i | wd_fire;
            end
            OWN_D: begin
                mwb_adr_o = dwb_adr_i;
                mwb_dat_o = dwb_dat_i;
                mwb_we_o  = dwb_we_i;
                mwb_sel_o = dwb_sel_i;
                mwb_cyc_o = dwb_cyc_i;
                mwb_stb_o = dwb_stb_i;
                dwb_dat_o = mwb_dat_i;
                dwb_ack_o = mwb_ack_i;
                dwb_err_o = mwb_err_i | wd_fire;
            end
            default: ;
        endcase
    end

    assign grant_o   = state_q;
    assign timeout_o = wd_fire;

endmodule

// File: doc/wb_unified_mem_arbiter.md
Name: wb_unified_mem_arbiter

Overview:
Two-master to one-slave Wishbone classic arbiter that shares the unified 32 KB code/data memory between the core's instruction port (iwb) and data port (dwb). It sits between custom_riscv_core and the unified memory, so self-modifying code and FENCE.I work against a single memory array. Grants are registered and held for the whole bus cycle. A bus-cycle watchdog returns an error to a master that is starved by a hung slave.

Parameters:
ARB_MODE, 0, 0 = round-robin on contention; 1 = fixed priority, data port wins.
TIMEOUT_CYCLES, 64, cycles a granted cycle may wait for ack/err before a forced error; 0 disables the watchdog.
CNT_W, 8, width of the watchdog counter; TIMEOUT_CYCLES must be < 2^CNT_W.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
iwb_adr_i  in  32  instruction fetch address
iwb_cyc_i  in  1  instruction cycle
iwb_stb_i  in  1  instruction strobe
iwb_dat_o  out  32  fetch read data
iwb_ack_o  out  1  fetch acknowledge
iwb_err_o  out  1  fetch error
dwb_adr_i  in  32  data address
dwb_dat_i  in  32  data write data
dwb_we_i  in  1  data write enable
dwb_sel_i  in  4  data byte selects
dwb_cyc_i  in  1  data cycle
dwb_stb_i  in  1  data strobe
dwb_dat_o  out  32  data read data
dwb_ack_o  out  1  data acknowledge
dwb_err_o  out  1  data error
mwb_adr_o  out  32  memory address
mwb_dat_o  out  32  memory write data
mwb_we_o  out  1  memory write enable
mwb_sel_o  out  4  memory byte selects
mwb_cyc_o  out  1  memory cycle
mwb_stb_o  out  1  memory strobe
mwb_dat_i  in  32  memory read data
mwb_ack_i  in  1  memory acknowledge
mwb_err_i  in  1  memory error
grant_o  out  2  current owner: 2'b00 none, 2'b01 instruction, 2'b10 data
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst: every register updates only on the rising edge of clk while rst=1.
- FSM states: IDLE, OWN_I, OWN_D. A 1-bit last_owner register and a CNT_W-bit watchdog counter complete the state.
- Reset: state=IDLE, last_owner=I, counter=0. Outputs after reset: grant_o=0, timeout_o=0, all mwb_* outputs=0, all *_ack_o and *_err_o=0, iwb_dat_o=0, dwb_dat_o=0.
- Requests: req_i = iwb_cyc_i & iwb_stb_i; req_d = dwb_cyc_i & dwb_stb_i.
- IDLE transitions:
  - Only req_i asserted: go to OWN_I.
  - Only req_d asserted: go to OWN_D.
  - Both asserted, ARB_MODE=1: go to OWN_D.
  - Both asserted, ARB_MODE=0: grant the port that is not last_owner; with the reset value, data wins the first tie.
  - On every grant, last_owner takes the granted port and the counter clears.
- The slave-side mux is combinational from the registered state. Arbitration latency is one cycle: mwb_stb_o rises in the cycle after the request is first seen in IDLE.
- OWN_I:
  - mwb_adr_o=iwb_adr_i, mwb_we_o=0, mwb_sel_o=4'hF, mwb_dat_o=0.
  - mwb_cyc_o=iwb_cyc_i, mwb_stb_o=iwb_stb_i.
  - iwb_ack_o=mwb_ack_i, iwb_err_o=mwb_err_i, iwb_dat_o=mwb_dat_i.
- OWN_D: the dwb_* inputs pass straight through to the mwb_* outputs, and mwb_* responses return on the dwb_* outputs.
- The non-owner port always sees ack=0, err=0, dat=0. grant_o reflects the state.
- Leaving OWN_x (to IDLE) happens on any of:
  - mwb_ack_i or mwb_err_i seen while owned;
  - the owner's cyc_i deasserting (abort);
  - the watchdog firing.
  The cycle after release is always IDLE, so a one-cycle bus gap separates transfers. No back-to-back grant without passing through IDLE.
- Watchdog, TIMEOUT_CYCLES>0:
  - The counter increments each owned cycle with no ack and no err.
  - When the counter equals TIMEOUT_CYCLES-1 and no ack/err arrives that cycle:
    - the owner's err_o=1 that same cycle;
    - timeout_o=1 that same cycle;
    - mwb_stb_o is still driven;
    - state goes to IDLE next cycle, which drops mwb_cyc_o.
- Simultaneous events:
  - A slave ack on the timeout cycle takes precedence: ack is forwarded, no err, no timeout_o.
  - If mwb_ack_i and mwb_err_i are asserted together, both are forwarded unchanged.
- Reset mid-transfer: at the reset edge, state goes to IDLE, mwb_cyc_o and mwb_stb_o drop, and any pending ack is discarded. Slave responses during IDLE are ignored and never forwarded.
- Masters must hold address, data, sel and we stable while owned (Wishbone classic). The arbiter does not register request data.

Test Plan:
- Reset held 3 cycles, then released with no requests -> grant_o=0, mwb_cyc_o=0, all acks=0.
- Fetch only: iwb request for 0x100, slave acks 1 cycle after stb, mwb_dat_i=0x00000013 -> mwb_stb_o rises 1 cycle after request, mwb_sel_o=4'hF, mwb_we_o=0, iwb_ack_o=1 with iwb_dat_o=0x00000013, grant_o back to 0 next cycle.
- Contention, ARB_MODE=0, both requesting continuously -> grants alternate D,I,D,I; dwb_ack_o never asserts while grant_o=2'b01. Same with ARB_MODE=1 -> D always wins while req_d is asserted.
- Data write: dwb adr 0x1000, dat 0xDEADBEEF, sel 4'b0011, we=1 -> identical values appear on mwb_*, and the slave ack is returned only on dwb_ack_o.
- Watchdog, TIMEOUT_CYCLES=4, slave never acks, data requesting -> dwb_err_o=1 and timeout_o=1 on the 4th owned cycle, mwb_cyc_o=0 next cycle. With the ack arriving on the 4th owned cycle -> ack forwarded, no err.
- rst asserted in the middle of an owned data cycle -> next cycle grant_o=0, mwb_cyc_o=0. A late mwb_ack_i is not forwarded to dwb_ack_o.
